// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: OFF/ON/BLINK/BREATHE per channel, shared PWM counter and
// shared tick prescaler, configured one channel at a time over a valid/ready port.
module led_pattern_gen #(
  parameter int unsigned CLK_HZ   = 12_000_000,
  parameter int unsigned TICK_HZ  = 1000,
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned PWM_BITS = 8,
  localparam int unsigned CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [15:0]         cfg_period,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic                cfg_err,
  output logic [NUM_CH-1:0]   led_n
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0]       PrescLast = PW'(DIV - 1);
  localparam logic [PW-1:0]       PrescOne  = PW'(1);
  localparam logic [PWM_BITS-1:0] LvlOne    = PWM_BITS'(1);

  localparam logic [1:0] ModeOff     = 2'd0;
  localparam logic [1:0] ModeOn      = 2'd1;
  localparam logic [1:0] ModeBlink   = 2'd2;
  localparam logic [1:0] ModeBreathe = 2'd3;

  logic [PW-1:0]       r_presc;
  logic [PWM_BITS-1:0] r_pwm;
  logic                r_ready;
  logic                r_err;
  logic [NUM_CH-1:0]   r_led_n;

  logic                w_tick;
  logic                w_accept;
  logic                w_ch_ok;
  logic [NUM_CH-1:0]   w_lit;

  assign w_tick   = (r_presc == PrescLast);
  assign w_accept = cfg_valid & r_ready;
  assign w_ch_ok  = (32'(cfg_ch) < NUM_CH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_pwm   <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_led_n <= '1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PrescOne;
      r_pwm   <= r_pwm + LvlOne;
      r_ready <= 1'b1;
      r_err   <= w_accept & ~w_ch_ok;
      r_led_n <= ~w_lit;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [1:0]          r_mode;
    logic [15:0]         r_period;
    logic [15:0]         r_tcnt;
    logic [PWM_BITS-1:0] r_duty;
    logic [PWM_BITS-1:0] r_level;
    logic                r_phase_off;
    logic                r_down;
    logic                w_load;
    logic                w_expire;
    logic [15:0]         w_last;
    logic [PWM_BITS-1:0] w_eff;

    assign w_load   = w_accept && (32'(cfg_ch) == g);
    // A programmed period of 0 behaves like 1.
    assign w_last   = (r_period == 16'd0) ? 16'd0 : r_period - 16'd1;
    assign w_expire = w_tick && (r_tcnt == w_last);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_mode      <= ModeOff;
        r_period    <= '0;
        r_duty      <= '0;
        r_tcnt      <= '0;
        r_level     <= '0;
        r_phase_off <= 1'b0;
        r_down      <= 1'b0;
      end else if (w_load) begin
        // Load takes priority over a coincident expire, which is dropped.
        r_mode      <= cfg_mode;
        r_period    <= cfg_period;
        r_duty      <= cfg_duty;
        r_tcnt      <= '0;
        r_level     <= '0;
        r_phase_off <= 1'b0;
        r_down      <= 1'b0;
      end else if (w_tick) begin
        if (w_expire) begin
          r_tcnt      <= '0;
          r_phase_off <= ~r_phase_off;
          if (r_mode == ModeBreathe) begin
            if (r_duty == '0) begin
              r_level <= '0;
            end else if (!r_down) begin
              if (r_level < r_duty) begin
                r_level <= r_level + LvlOne;
              end else begin
                r_down  <= 1'b1;
                r_level <= r_level - LvlOne;
              end
            end else begin
              if (r_level != '0) begin
                r_level <= r_level - LvlOne;
              end else begin
                r_down  <= 1'b0;
                r_level <= r_level + LvlOne;
              end
            end
          end
        end else begin
          r_tcnt <= r_tcnt + 16'd1;
        end
      end
    end

    always_comb begin
      w_eff = '0;
      unique case (r_mode)
        ModeOn:      w_eff = r_duty;
        ModeBlink:   w_eff = r_phase_off ? '0 : r_duty;
        ModeBreathe: w_eff = r_level;
        default:     w_eff = '0;
      endcase
    end

    assign w_lit[g] = (r_pwm < w_eff);
  end

  assign cfg_ready = r_ready;
  assign cfg_err   = r_err;
  assign led_n     = r_led_n;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: directed table, hand-written corner sequences and
// random configuration traffic against a cycle-accurate behavioural model.
module tb_led_pattern_gen;

  localparam int NCH = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [15:0] cfg_period = '0;
  logic [3:0] cfg_duty = '0;
  logic       cfg_err;
  logic [2:0] led_n;

  int checks = 0;
  int errors = 0;

  led_pattern_gen #(
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .NUM_CH  (3),
    .PWM_BITS(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_period(cfg_period),
    .cfg_duty  (cfg_duty),
    .cfg_err   (cfg_err),
    .led_n     (led_n)
  );

  always #5 clk = ~clk;

  // Reference model state: plain integers, n counts clock edges since reset.
  int         m_mode[NCH], m_per[NCH], m_duty[NCH], m_tcnt[NCH], m_level[NCH];
  bit         m_on[NCH], m_up[NCH];
  int         m_n;
  bit         m_ready, m_err;
  logic [2:0] m_led;

  function automatic int per_of(int i);
    return (m_per[i] == 0) ? 1 : m_per[i];
  endfunction

  function automatic int eff_level(int i);
    case (m_mode[i])
      1:       return m_duty[i];
      2:       return m_on[i] ? m_duty[i] : 0;
      3:       return m_level[i];
      default: return 0;
    endcase
  endfunction

  task automatic model_expire(input int i);
    if (m_mode[i] == 2) m_on[i] = !m_on[i];
    if (m_mode[i] == 3) begin
      if (m_duty[i] == 0) m_level[i] = 0;
      else if (m_up[i]) begin
        if (m_level[i] < m_duty[i]) m_level[i]++;
        else begin m_up[i] = 0; m_level[i]--; end
      end else begin
        if (m_level[i] > 0) m_level[i]--;
        else begin m_up[i] = 1; m_level[i]++; end
      end
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input int ch, input int md, input int per,
                            input int dt);
    logic [2:0] nled;
    bit acc, tick;
    if (r) begin
      for (int i = 0; i < NCH; i++) begin
        m_mode[i] = 0; m_per[i] = 0; m_duty[i] = 0; m_tcnt[i] = 0; m_level[i] = 0;
        m_on[i] = 0; m_up[i] = 1;
      end
      m_n = 0; m_ready = 0; m_err = 0; m_led = 3'b111;
      return;
    end
    for (int i = 0; i < NCH; i++) nled[i] = !((m_n % 16) < eff_level(i));
    acc  = m_ready && v && (ch < NCH);
    tick = (m_n % 10) == 9;
    for (int i = 0; i < NCH; i++) begin
      if (acc && ch == i) begin
        m_mode[i] = md; m_per[i] = per; m_duty[i] = dt;
        m_tcnt[i] = 0; m_on[i] = 1; m_level[i] = 0; m_up[i] = 1;
      end else if (tick) begin
        if (m_tcnt[i] == per_of(i) - 1) begin
          m_tcnt[i] = 0;
          model_expire(i);
        end else begin
          m_tcnt[i]++;
        end
      end
    end
    m_err   = m_ready && v && (ch >= NCH);
    m_ready = 1;
    m_n++;
    m_led   = nled;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual %0d required %0d", nm, $time, act, exp);
    end
  endtask

  task automatic reset_edge();
    @(negedge clk);
    rst = 1'b1;
    cfg_valid = 1'b0;
    @(posedge clk);
    model_edge(1, 0, 0, 0, 0, 0);
    #1;
    chk("rst_led_n", int'(led_n), 7);
    chk("rst_ready", int'(cfg_ready), 0);
    chk("rst_err", int'(cfg_err), 0);
  endtask

  task automatic step(input bit v, input int ch, input int md, input int per, input int dt);
    @(negedge clk);
    rst        = 1'b0;
    cfg_valid  = v;
    cfg_ch     = 2'(ch);
    cfg_mode   = 2'(md);
    cfg_period = 16'(per);
    cfg_duty   = 4'(dt);
    @(posedge clk);
    model_edge(0, v, ch, md, per, dt);
    #1;
    chk("model_led_n", int'(led_n), int'(m_led));
    chk("model_err", int'(cfg_err), int'(m_err));
    chk("model_ready", int'(cfg_ready), int'(m_ready));
  endtask

  task automatic idle_lows(input int n, input int ch, output int lows);
    lows = 0;
    for (int k = 0; k < n; k++) begin
      step(0, 0, 0, 0, 0);
      lows += (led_n[ch] == 1'b0) ? 1 : 0;
    end
  endtask

  typedef struct {
    int ch; int mode; int period; int duty;
    int chk_ch; int exp_err; int exp_low;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int lows;
    int waited;
    bit hit;

    tbl[0] = '{0, 1, 1, 8,  0, 0, 8};
    tbl[1] = '{0, 1, 1, 15, 0, 0, 15};
    tbl[2] = '{0, 1, 1, 0,  0, 0, 0};
    tbl[3] = '{0, 1, 1, 5,  0, 0, 5};
    tbl[4] = '{3, 1, 1, 12, 0, 1, 5};
    tbl[5] = '{1, 0, 1, 9,  1, 0, 0};
    tbl[6] = '{0, 0, 1, 0,  0, 0, 0};

    for (int c = 0; c < 3; c++) reset_edge();
    step(0, 0, 0, 0, 0);
    chk("ready_after_release", int'(cfg_ready), 1);

    // Directed ON / OFF / invalid-channel words, low-count over one full PWM period.
    for (int t = 0; t < 7; t++) begin
      step(1, tbl[t].ch, tbl[t].mode, tbl[t].period, tbl[t].duty);
      chk("tbl_err", int'(cfg_err), tbl[t].exp_err);
      idle_lows(16, tbl[t].chk_ch, lows);
      chk("tbl_low", lows, tbl[t].exp_low);
    end

    // BLINK: in steady state, 60 clocks hold one 30-clock lit window (minus pwm==15 slots).
    step(1, 1, 2, 3, 15);
    idle_lows(40, 1, lows);
    idle_lows(60, 1, lows);
    chk("blink_window_low", (lows >= 27 && lows <= 30) ? 1 : 0, 1);

    // BREATHE on ch2 while ch1 keeps blinking.
    step(1, 2, 3, 1, 3);
    idle_lows(120, 2, lows);
    chk("breathe_active", (lows > 0) ? 1 : 0, 1);

    // Reconfigure ch1 exactly when it would leave its ON phase: it must stay ON.
    hit = 0;
    waited = 0;
    while (!hit && waited < 200) begin
      if ((m_n % 10) == 9 && m_tcnt[1] == per_of(1) - 1 && m_on[1] && m_mode[1] == 2) hit = 1;
      else begin step(0, 0, 0, 0, 0); waited++; end
    end
    chk("collision_found", int'(hit), 1);
    if (hit) begin
      step(1, 1, 2, 3, 15);
      idle_lows(16, 1, lows);
      chk("collision_stays_on", lows, 15);
    end

    // Reset in the middle of BREATHE: everything dark and OFF afterwards.
    reset_edge();
    step(0, 0, 0, 0, 0);
    lows = 0;
    for (int k = 0; k < 40; k++) begin
      step(0, 0, 0, 0, 0);
      lows += (led_n != 3'b111) ? 1 : 0;
    end
    chk("dark_after_reset", lows, 0);

    // Random configuration traffic, including period 0 and invalid channels.
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 11) == 0)
        step(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      else
        step(0, 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Multi-channel, runtime-configurable LED pattern generator for the iCESugar UP5K board family, replacing fixed single-LED blinkers. Each of `NUM_CH` active-low LED outputs independently runs OFF, ON, BLINK or BREATHE. Brightness comes from a shared PWM counter. Timing derives from a shared millisecond tick. Configuration arrives one channel at a time over a valid/ready port driven by the PLC runtime or a boot-time ROM sequencer.

## Interface
- `CLK_HZ`, default 12_000_000: input clock frequency.
- `TICK_HZ`, default 1000: timebase tick rate; `CLK_HZ/TICK_HZ` must be ≥ 2 and is truncated to an integer.
- `NUM_CH`, default 3: number of LED channels, ≥ 1.
- `PWM_BITS`, default 8: PWM and brightness resolution.
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `cfg_valid`, in, 1: config word present.
- `cfg_ready`, out, 1: block can accept config.
- `cfg_ch`, in, `CW = max(1, $clog2(NUM_CH))`: target channel.
- `cfg_mode`, in, 2: 0 OFF, 1 ON, 2 BLINK, 3 BREATHE.
- `cfg_period`, in, 16: BLINK half-period or BREATHE step interval, in ticks; 0 is treated as 1.
- `cfg_duty`, in, `PWM_BITS`: ON/BLINK brightness, BREATHE peak.
- `cfg_err`, out, 1: one-cycle pulse when a word with `cfg_ch >= NUM_CH` is accepted.
- `led_n`, out, `NUM_CH`: active-low LED drives, registered.

## Operation
- **Reset.** Every channel goes to mode OFF, period 0, duty 0, phase 0, level 0, direction up. The prescaler, tick and `pwm_cnt` clear to 0. Output reset values:
  - `led_n` = all ones
  - `cfg_ready` = 0
  - `cfg_err` = 0
- **Ready.** `cfg_ready` is a register. It is 0 while `rst` is high and becomes 1 on the first edge with `rst` low. It stays 1 thereafter.
- **Accept.** A config word is accepted on an edge where `cfg_valid & cfg_ready` is true.
  - Valid `cfg_ch`: that channel's mode, period and duty load, and its pattern restarts. The tick counter goes to 0, phase to ON, level to 0 and direction to up.
  - Invalid `cfg_ch`: the word is dropped, no channel state changes, and `cfg_err` = 1 for exactly the next cycle.
  - At most one word is accepted per cycle.
- **Prescaler.** Counts 0 to `CLK_HZ/TICK_HZ - 1`. `tick` is asserted for one cycle at terminal count, then the prescaler wraps.
- **PWM.** `pwm_cnt` is `PWM_BITS` wide, increments every cycle and wraps. A channel lights when `pwm_cnt < level_eff`. With this rule, duty 2^PWM_BITS-1 gives (2^PWM_BITS-1)/2^PWM_BITS on-time, and duty 0 is dark.
- **Per-channel tick counter.** 16 bits. On `tick` it increments. When it equals `max(period,1) - 1` it instead wraps to 0 and raises `expire` for that cycle.
- **Modes.**
  - OFF: `level_eff` = 0.
  - ON: `level_eff` = duty.
  - BLINK: phase toggles on `expire`. `level_eff` = duty when phase is ON, 0 otherwise.
  - BREATHE: on `expire`:
    - Up direction: if level < duty, level += 1; else direction flips to down and level -= 1.
    - Down direction: if level > 0, level -= 1; else direction flips to up and level += 1.
    - If duty = 0, level stays 0.
    - `level_eff` = level.
- **Simultaneous events.** If an accept and `expire` hit the same channel in the same cycle, the accept wins and the `expire` is discarded. Accepts to other channels do not disturb a channel's state.
- **Reset mid-operation.** Every register takes its reset value on that edge. Nothing is retained.

## Timing
- Accept at edge k: channel state is updated at k. `led_n` first reflects the new configuration after edge k+1 (1-cycle output latency).
- `cfg_err` is high during the cycle between edges k and k+1 only.
- BLINK: each phase lasts exactly `max(period,1)` ticks. The first ON phase may be up to one prescaler interval shorter, because the prescaler is shared and not restarted on accept.
- BREATHE: each level is held for `max(period,1)` ticks. A full cycle is `2*duty` steps.
- `led_n[i]` changes only at clock edges. There are no combinational paths from inputs to `led_n`.

## Test plan
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (10 clocks per tick), NUM_CH=3, PWM_BITS=4.
1. **Reset.** Hold `rst` for 3 cycles, then release -> `led_n`=3'b111 and `cfg_ready`=0 throughout reset; `cfg_ready`=1 after the first post-release edge; `cfg_err` never asserts.
2. **ON.** ch0, duty 8 -> `led_n[0]` low for exactly 8 of every 16 cycles, starting 1 cycle after accept; ch1 and ch2 stay 1.
3. **BLINK.** ch1, period 3, duty 15 -> after the first phase, `led_n[1]` alternates between 30-clock windows with PWM activity (15/16 low) and 30-clock windows that are solid high.
4. **BREATHE.** ch2, period 1, duty 3 -> level sequence 0,1,2,3,2,1,0,1,… with each value held for 10 clocks; low-time per 16-cycle window matches the level.
5. **Invalid channel.** `cfg_ch`=3 -> `cfg_err` pulses for 1 cycle and all channel outputs are unchanged.
6. **Collision and reset.**
   - Reconfigure ch1 on the exact cycle of its `expire` -> the phase restarts ON and there is no toggle.
   - Then assert `rst` mid-BREATHE -> `led_n`=3'b111 after the next edge, and all channels are OFF after release.
